// File: rtl/fc_pkg.sv
// Shared fixed-point constants and state encoding for the fc stream blocks.
// Q16.15 sign-magnitude payloads; sample RAM has a one-cycle read latency.
package fc_pkg;

    localparam int Q        = 15;
    localparam int N        = 32;
    localparam int SIGN_BIT = N - 1;
    localparam int RD_LAT   = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fc_state_t;

endpackage

// File: rtl/fc_skid2.sv
// Two-entry in-order buffer; entry e0 is always the head.
// flush empties it, and a push and a pop in the same cycle keep occupancy.
module fc_skid2
    import fc_pkg::*;
#(
    parameter int W = N
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);

    logic [W-1:0] e0;
    logic [W-1:0] e1;

    assign dout = e0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0  <= '0;
            e1  <= '0;
            occ <= 2'd0;
        end else if (flush) begin
            occ <= 2'd0;
        end else begin
            unique case (1'b1)
                push && pop: begin
                    if (occ == 2'd2) begin
                        e0 <= e1;
                        e1 <= din;
                    end else begin
                        e0 <= din;
                    end
                end
                push && !pop: begin
                    if (occ == 2'd0)
                        e0 <= din;
                    else
                        e1 <= din;
                    occ <= occ + 2'd1;
                end
                pop && !push: begin
                    e0  <= e1;
                    occ <= occ - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fc_stream_tx.sv
// Streams count words from the sample RAM as (value, index) beats.
// FC_TX_NEGZERO_CLEAN_EN: send negative zero as +0.
module fc_stream_tx
    import fc_pkg::*;
#(
    parameter int IDX_WIDTH  = 10,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [IDX_WIDTH:0]    count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_odata,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]  out_idx,
    input  logic                  out_rdy
);

    localparam int CW = IDX_WIDTH + 1;

    fc_state_t             state;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         accepted;
    logic [CW-1:0]         outstanding;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  rd_pend;
    logic                  xfer;
    logic                  issue;
    logic                  last;
    logic [1:0]            occ;
    logic [DATA_WIDTH-1:0] push_data;

`ifdef FC_TX_NEGZERO_CLEAN_EN
    localparam logic [DATA_WIDTH-1:0] NEG_ZERO =
        {1'b1, {(DATA_WIDTH-1){1'b0}}};
    assign push_data =
        (mem_odata == NEG_ZERO) ? '0 : mem_odata;
`else
    assign push_data = mem_odata;
`endif

    assign xfer        = out_valid && out_rdy && !abort;
    assign outstanding = issued - accepted;
    assign last        = (accepted == cnt - CW'(1));

    // A beat accepted this cycle frees its slot for a read this cycle,
    // which is what sustains one beat per cycle with only two slots.
    assign issue = (state == RUN) && !abort
                && (issued != cnt)
                && ((outstanding < CW'(2))
                 || ((outstanding == CW'(2)) && xfer));

    assign mem_re    = issue;
    assign mem_addr  = addr;
    assign out_valid = (occ != 2'd0);
    assign out_idx   = accepted[IDX_WIDTH-1:0];

    fc_skid2 #(
        .W(DATA_WIDTH)
    ) u_skid (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(abort),
        .push (rd_pend),
        .din  (push_data),
        .pop  (xfer),
        .dout (out_data),
        .occ  (occ)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            issued   <= '0;
            accepted <= '0;
            addr     <= '0;
            rd_pend  <= 1'b0;
        end else begin
            rd_pend <= issue;
            done    <= 1'b0;
            if (issue) begin
                issued <= issued + CW'(1);
                addr   <= addr + ADDR_WIDTH'(1);
            end
            if (xfer)
                accepted <= accepted + CW'(1);
            if (abort) begin
                state    <= IDLE;
                busy     <= 1'b0;
                issued   <= '0;
                accepted <= '0;
                rd_pend  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && count != '0) begin
                            state    <= RUN;
                            busy     <= 1'b1;
                            cnt      <= count;
                            addr     <= base_addr;
                            issued   <= '0;
                            accepted <= '0;
                        end else if (start) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (xfer && last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fc_stream_tx.sv
// Directed bench for fc_stream_tx with a synchronous-read RAM model.
// Beats, read addresses and done pulses are logged at each rising edge.
`timescale 1ns/1ps
module tb_fc_stream_tx;

    localparam int IW = 10;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic          out_rdy   = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [IW:0]   count     = '0;
    logic          busy;
    logic          done;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_odata = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_idx;

    logic [DW-1:0] ram [0:1023];

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int vld_cnt  = 0;
    int outst    = 0;
    int max_out  = 0;

    bit            hold_pend = 1'b0;
    logic [DW-1:0] hold_d;
    logic [IW-1:0] hold_i;

    logic [DW-1:0] data_q [$];
    logic [IW-1:0] idx_q  [$];
    logic [AW-1:0] addr_q [$];

    always #5 clk = ~clk;

    fc_stream_tx #(
        .IDX_WIDTH (IW),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .base_addr(base_addr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .mem_re   (mem_re),
        .mem_addr (mem_addr),
        .mem_odata(mem_odata),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_idx  (out_idx),
        .out_rdy  (out_rdy)
    );

    always @(posedge clk)
        if (mem_re) mem_odata <= ram[mem_addr];

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            if (hold_pend) begin
                chk("hold_vld", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(hold_d));
                chk("hold_idx", 64'(out_idx), 64'(hold_i));
            end
            hold_pend = out_valid && !out_rdy && !abort;
            hold_d    = out_data;
            hold_i    = out_idx;
            if (mem_re) addr_q.push_back(mem_addr);
            if (out_valid) vld_cnt++;
            if (done) done_cnt++;
            if (out_valid && out_rdy && !abort) begin
                data_q.push_back(out_data);
                idx_q.push_back(out_idx);
            end
            if (abort)
                outst = 0;
            else
                outst = outst + int'(mem_re)
                      - int'(out_valid && out_rdy);
            if (outst > max_out) max_out = outst;
        end else begin
            hold_pend = 1'b0;
            outst     = 0;
        end
    end

    task automatic clear_q();
        data_q.delete();
        idx_q.delete();
        addr_q.delete();
        max_out = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b,
                               input logic [IW:0] c);
        @(negedge clk);
        base_addr = b;
        count     = c;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit tog);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            if (tog) out_rdy = (k % 4 == 0) || (k % 4 == 3);
            k++;
        end
        chk("done_seen", 64'(done_cnt - d0), 64'd1);
    endtask

    task automatic check_beats(input string tag,
                               input logic [AW-1:0] b,
                               input int n);
        logic [AW-1:0] a;
        chk({tag, "_n"}, 64'(data_q.size()), 64'(n));
        for (int i = 0; i < n && i < data_q.size(); i++) begin
            a = b + AW'(i);
            chk({tag, "_data"}, 64'(data_q[i]), 64'(ram[a]));
            chk({tag, "_idx"}, 64'(idx_q[i]), 64'(i));
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_re"}, 64'(mem_re), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_vld"}, 64'(out_valid), 64'd0);
        chk({tag, "_data"}, 64'(out_data), 64'd0);
        chk({tag, "_idx"}, 64'(out_idx), 64'd0);
    endtask

    initial begin
        int d0;
        int v0;
        logic [DW-1:0] g;
        logic [DW-1:0] nz_exp;

        for (int i = 0; i < 1024; i++)
            ram[i] = 32'h1000_0000 + 32'(i);
        ram[10'h010] = 32'd1;
        ram[10'h011] = 32'd2;
        ram[10'h012] = 32'd3;
        ram[10'h013] = 32'd4;
        ram[10'h080] = 32'h8000_0000;
        ram[10'h081] = 32'h0000_0005;

        #3 chk_reset_outs("rst");
        #20;
        @(negedge clk) rst_n = 1'b1;

        // basic 4-beat transfer, out_rdy high
        out_rdy = 1'b1;
        clear_q();
        pulse_start(10'h010, 11'd4);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_vld_e0", 64'(out_valid), 64'd0);
        @(posedge clk) #1;
        chk("t1_vld_e1", 64'(out_valid), 64'd0);
        @(posedge clk) #1;
        chk("t1_vld_e2", 64'(out_valid), 64'd1);
        chk("t1_d0", 64'(out_data), 64'd1);
        chk("t1_i0", 64'(out_idx), 64'd0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk) #1;
            chk("t1_vld", 64'(out_valid), 64'd1);
            chk("t1_d", 64'(out_data), 64'(i + 1));
            chk("t1_i", 64'(out_idx), 64'(i));
        end
        @(posedge clk) #1;
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_vld_end", 64'(out_valid), 64'd0);
        chk("t1_busy_end", 64'(busy), 64'd0);
        @(posedge clk) #1;
        chk("t1_done_off", 64'(done), 64'd0);
        chk("t1_busy_off", 64'(busy), 64'd0);
        chk("t1_nrd", 64'(addr_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < addr_q.size(); i++)
            chk("t1_addr", 64'(addr_q[i]), 64'(16 + i));
        check_beats("t1", 10'h010, 4);

        // same transfer with out_rdy toggling 1,0,0,1
        clear_q();
        out_rdy = 1'b0;
        pulse_start(10'h010, 11'd4);
        wait_done(80, 1'b1);
        out_rdy = 1'b1;
        check_beats("t2", 10'h010, 4);
        chk("t2_max_out", 64'(max_out), 64'd2);

        // address wrap
        clear_q();
        pulse_start(10'h3FE, 11'd4);
        wait_done(40, 1'b0);
        chk("t3_nrd", 64'(addr_q.size()), 64'd4);
        if (addr_q.size() == 4) begin
            chk("t3_a0", 64'(addr_q[0]), 64'h3FE);
            chk("t3_a1", 64'(addr_q[1]), 64'h3FF);
            chk("t3_a2", 64'(addr_q[2]), 64'h000);
            chk("t3_a3", 64'(addr_q[3]), 64'h001);
        end
        check_beats("t3", 10'h3FE, 4);

        // count = 0
        clear_q();
        d0 = done_cnt;
        v0 = vld_cnt;
        pulse_start(10'h020, 11'd0);
        chk("t4_done", 64'(done), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_done_n", 64'(done_cnt - d0), 64'd1);
        chk("t4_nrd", 64'(addr_q.size()), 64'd0);
        chk("t4_nvld", 64'(vld_cnt - v0), 64'd0);

        // start while busy is ignored
        clear_q();
        pulse_start(10'h020, 11'd8);
        repeat (3) @(negedge clk);
        base_addr = 10'h100;
        count     = 11'd2;
        start     = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(60, 1'b0);
        check_beats("t5", 10'h020, 8);

        // abort while beat 2 of 8 is stalled
        clear_q();
        d0 = done_cnt;
        pulse_start(10'h040, 11'd8);
        for (int k = 0; k < 20 && data_q.size() < 2; k++)
            @(negedge clk);
        out_rdy = 1'b0;
        chk("t6_pre_n", 64'(data_q.size()), 64'd2);
        @(negedge clk);
        chk("t6_st_vld", 64'(out_valid), 64'd1);
        chk("t6_st_idx", 64'(out_idx), 64'd2);
        chk("t6_st_data", 64'(out_data), 64'(ram[10'h042]));
        abort = 1'b1;
        @(posedge clk) #1;
        abort = 1'b0;
        chk("t6_ab_vld", 64'(out_valid), 64'd0);
        chk("t6_ab_busy", 64'(busy), 64'd0);
        chk("t6_ab_done", 64'(done), 64'd0);
        repeat (4) @(negedge clk);
        chk("t6_post_vld", 64'(out_valid), 64'd0);
        chk("t6_post_done", 64'(done_cnt - d0), 64'd0);
        chk("t6_post_n", 64'(data_q.size()), 64'd2);
        out_rdy = 1'b1;
        clear_q();
        pulse_start(10'h040, 11'd3);
        wait_done(40, 1'b0);
        check_beats("t6r", 10'h040, 3);

        // negative zero payload
        clear_q();
        pulse_start(10'h080, 11'd2);
        wait_done(40, 1'b0);
`ifdef FC_TX_NEGZERO_CLEAN_EN
        nz_exp = 32'h0000_0000;
`else
        nz_exp = 32'h8000_0000;
`endif
        chk("t7_n", 64'(data_q.size()), 64'd2);
        g = (data_q.size() > 0) ? data_q[0] : 'x;
        chk("t7_negzero", 64'(g), 64'(nz_exp));
        g = (data_q.size() > 1) ? data_q[1] : 'x;
        chk("t7_b1", 64'(g), 64'h5);

        // asynchronous reset mid-transfer
        clear_q();
        pulse_start(10'h020, 11'd8);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset_outs("t8");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("t8_idle_busy", 64'(busy), 64'd0);
        chk("t8_idle_vld", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
